// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: segment bit positions,
// whole-bus patterns and the active-high hex font.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] SEG_ALL = 8'hFF;

  // Entry n is the a..g pattern for nibble n; index 0 is the rightmost literal.
  localparam logic [15:0][7:0] FONT_TBL = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Application-side port group of the scan controller: digit data, capture
// strobe, live display controls and the update-complete pulse.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIG = 8
) ();

  // Handshake: din_vld is a one-cycle strobe with no back-pressure; the
  // controller captures din/dp_in/dig_en on every strobe (last one wins) and
  // answers with a one-cycle upd_done when that data reaches the display at a
  // frame boundary. lz_en and bright are level controls sampled every cycle.
  logic [4*NUM_DIG-1:0] din;
  logic [NUM_DIG-1:0]   dp_in;
  logic [NUM_DIG-1:0]   dig_en;
  logic                 din_vld;
  logic                 lz_en;
  logic [3:0]           bright;
  logic                 upd_done;

  modport master (
    output din, dp_in, dig_en, din_vld, lz_en, bright,
    input  upd_done
  );

  modport slave (
    input  din, dp_in, dig_en, din_vld, lz_en, bright,
    output upd_done
  );

endinterface

// File: rtl/seg_hex_font.sv
// Combinational hex-to-7-segment decoder with decimal point and blanking of
// a-g for suppressed leading zeros. Output is active-high.
module seg_hex_font
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       supp,
  output logic [7:0] pat
);

  logic [7:0] glyph;

  assign glyph = FONT_TBL[nib];

  always_comb begin
    pat = SEG_OFF;
    if (!supp) begin
      pat[SEG_G:SEG_A] = glyph[SEG_G:SEG_A];
    end
    // The decimal point survives suppression so "0.5"-style readouts work.
    pat[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: slot/digit/PWM counters, double-
// buffered digit data swapped at frame boundaries, and registered pin outputs.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIG     = 8,
  parameter int SCAN_DIV    = 20000,
  parameter int BLANK_CYC   = 16,
  parameter int SEL_ACT_LOW = 0,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_ctrl_if.slave     bus,
  output logic [NUM_DIG-1:0] sel,
  output logic [7:0]         seg
);

  localparam int   DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int   DIG_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic SEL_INV = (SEL_ACT_LOW != 0);
  localparam logic SEG_INV = (SEG_ACT_LOW != 0);

  logic [DIV_W-1:0] div_cnt;
  logic [DIG_W-1:0] dig_idx;
  logic [3:0]       pwm_cnt;
  logic             slot_end;
  logic             frame_end;

  assign slot_end  = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (dig_idx == DIG_W'(NUM_DIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dig_idx <= '0;
      pwm_cnt <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      dig_idx <= (dig_idx == DIG_W'(NUM_DIG - 1)) ? '0 : dig_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Pending registers take every strobe; active registers change only at a
  // frame boundary so a frame never mixes old and new digits.
  logic [4*NUM_DIG-1:0] pend_din;
  logic [NUM_DIG-1:0]   pend_dp;
  logic [NUM_DIG-1:0]   pend_en;
  logic                 pend;
  logic [4*NUM_DIG-1:0] act_din;
  logic [NUM_DIG-1:0]   act_dp;
  logic [NUM_DIG-1:0]   act_en;
  logic                 upd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_din <= '0;
      pend_dp  <= '0;
      pend_en  <= '0;
      pend     <= 1'b0;
      act_din  <= '0;
      act_dp   <= '0;
      act_en   <= '0;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= frame_end && pend;
      if (frame_end && pend) begin
        act_din <= pend_din;
        act_dp  <= pend_dp;
        act_en  <= pend_en;
      end
      // A strobe on the boundary cycle refills pending after the old
      // contents were transferred, and stays queued for the next frame.
      if (bus.din_vld) begin
        pend_din <= bus.din;
        pend_dp  <= bus.dp_in;
        pend_en  <= bus.dig_en;
        pend     <= 1'b1;
      end else if (frame_end) begin
        pend <= 1'b0;
      end
    end
  end

  assign bus.upd_done = upd_q;

  // zero_above[i]: nibble i and every nibble above it are zero.
  logic [NUM_DIG-1:0] zero_above;
  logic               zero_acc;

  always_comb begin
    zero_above = '0;
    zero_acc   = 1'b1;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      zero_acc      = zero_acc & (act_din[4*i +: 4] == 4'h0);
      zero_above[i] = zero_acc;
    end
  end

  logic [3:0]         cur_nib;
  logic               cur_dp;
  logic               cur_en;
  logic               cur_supp;
  logic               lit;
  logic [7:0]         font_pat;
  logic [NUM_DIG-1:0] dig_onehot;

  assign cur_nib  = act_din[4*dig_idx +: 4];
  assign cur_dp   = act_dp[dig_idx];
  assign cur_en   = act_en[dig_idx];
  assign cur_supp = bus.lz_en && (dig_idx != '0) && zero_above[dig_idx];
  assign lit      = (div_cnt >= DIV_W'(BLANK_CYC)) && (pwm_cnt <= bus.bright) && cur_en;

  always_comb begin
    dig_onehot          = '0;
    dig_onehot[dig_idx] = 1'b1;
  end

  seg_hex_font u_font (
    .nib  (cur_nib),
    .dp   (cur_dp),
    .supp (cur_supp),
    .pat  (font_pat)
  );

  // Polarity is applied at the register so the pins never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= {NUM_DIG{SEL_INV}};
      seg <= SEG_OFF ^ {8{SEG_INV}};
    end else begin
      sel <= (lit ? dig_onehot : '0) ^ {NUM_DIG{SEL_INV}};
      seg <= (lit ? font_pat : SEG_OFF) ^ {8{SEG_INV}};
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: random and directed digit updates checked against a
// frame-arithmetic reference model, plus directed pattern counts per scenario.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 20;
  localparam int BC    = 2;
  localparam int FRAME = SD * ND;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [ND-1:0] sel;
  logic [7:0]    seg;

  seg_scan_ctrl_if #(.NUM_DIG(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIG     (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYC   (BC),
    .SEL_ACT_LOW (0),
    .SEG_ACT_LOW (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sel   (sel),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] font_ref [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Reference model: time since reset release decides slot, digit and PWM
  // phase; two data copies model the pending/active pair.
  int              m_t     = 0;
  logic [15:0]     m_act_d = '0;
  logic [3:0]      m_act_p = '0;
  logic [3:0]      m_act_e = '0;
  logic [15:0]     m_pnd_d = '0;
  logic [3:0]      m_pnd_p = '0;
  logic [3:0]      m_pnd_e = '0;
  logic            m_pend  = 1'b0;
  logic            exp_upd = 1'b0;
  logic [ND-1:0]   exp_sel = '0;
  logic [7:0]      exp_seg = 8'hFF;

  function automatic logic [12:0] predict(input int t, input logic [15:0] ad,
                                          input logic [3:0] adp, input logic [3:0] aen,
                                          input logic lz, input logic [3:0] br,
                                          input logic pend);
    int         pos;
    int         dig;
    logic       lit;
    logic       supp;
    logic       fe;
    logic [3:0] nib;
    logic [7:0] pat;
    pos  = t % SD;
    dig  = (t / SD) % ND;
    lit  = (pos >= BC) && ((pos % 16) <= int'(br)) && aen[dig];
    nib  = 4'((ad >> (4 * dig)) & 16'hF);
    supp = lz && (dig > 0) && ((ad >> (4 * dig)) == 16'h0);
    pat  = supp ? 8'h00 : font_ref[nib];
    pat[7] = adp[dig];
    fe   = (t % FRAME) == FRAME - 1;
    return {fe && pend, lit ? 4'(1 << dig) : 4'b0000, lit ? ~pat : 8'hFF};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t     <= 0;
      m_act_d <= '0;
      m_act_p <= '0;
      m_act_e <= '0;
      m_pnd_d <= '0;
      m_pnd_p <= '0;
      m_pnd_e <= '0;
      m_pend  <= 1'b0;
      exp_upd <= 1'b0;
      exp_sel <= '0;
      exp_seg <= 8'hFF;
    end else begin
      {exp_upd, exp_sel, exp_seg} <= predict(m_t, m_act_d, m_act_p, m_act_e,
                                             bus.lz_en, bus.bright, m_pend);
      if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
        m_act_d <= m_pnd_d;
        m_act_p <= m_pnd_p;
        m_act_e <= m_pnd_e;
      end
      if (bus.din_vld) begin
        m_pnd_d <= bus.din;
        m_pnd_p <= bus.dp_in;
        m_pnd_e <= bus.dig_en;
        m_pend  <= 1'b1;
      end else if ((m_t % FRAME) == FRAME - 1) begin
        m_pend <= 1'b0;
      end
      m_t <= m_t + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_now(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    bus.din     = d;
    bus.dp_in   = dp;
    bus.dig_en  = en;
    bus.din_vld = 1'b1;
    @(negedge clk);
    bus.din_vld = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    @(negedge clk);
    pulse_now(d, dp, en);
  endtask

  task automatic wait_upd(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 3 * FRAME && !seen; c++) begin
      @(negedge clk);
      seen = bus.upd_done;
    end
  endtask

  task automatic wait_phase(input int ph);
    for (int c = 0; c < 2 * FRAME && (m_t % FRAME) != ph; c++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.din = '0; bus.dp_in = '0; bus.dig_en = '0; bus.din_vld = 1'b0;
    bus.lz_en = 1'b0; bus.bright = 4'd15;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (sel !== 4'b0000 || seg !== 8'hFF || bus.upd_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: sel=%b seg=%h upd=%b, expected 0000 ff 0", sel, seg, bus.upd_done);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      vectors++;
      if (sel !== 4'b0000 || seg !== 8'hFF || bus.upd_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle c=%0d: sel=%b seg=%h upd=%b, expected 0000 ff 0", c, sel, seg, bus.upd_done);
      end
    end
  endtask

  task automatic test_basic();
    bit seen;
    int cnt [ND];
    logic [7:0] want [ND] = '{8'h8E, 8'h88, 8'h24, 8'hF9};
    bus.bright = 4'd15; bus.lz_en = 1'b0;
    send(16'h12AF, 4'b0100, 4'hF);
    wait_upd(seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL basic_upd: upd_done=0, expected 1 within %0d cycles", 3 * FRAME); end
    foreach (cnt[d]) cnt[d] = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) if (sel === 4'(1 << d) && seg === want[d]) cnt[d]++;
      vectors++;
      if ({bus.upd_done, sel, seg} !== {exp_upd, exp_sel, exp_seg}) begin
        miscompares++;
        $display("FAIL basic_model t=%0d: got %b/%b/%h, expected %b/%b/%h", m_t, bus.upd_done, sel, seg, exp_upd, exp_sel, exp_seg);
      end
    end
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (cnt[d] != SD - BC) begin
        miscompares++;
        $display("FAIL basic_digit%0d: %0d lit cycles showing %h, expected %0d", d, cnt[d], want[d], SD - BC);
      end
    end
  endtask

  task automatic test_pwm();
    bit seen;
    int lit_cnt = 0;
    int first_lit = -1;
    bus.bright = 4'd3;
    send(16'h0008, 4'b0000, 4'hF);
    wait_upd(seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL pwm_upd: upd_done=0, expected 1"); end
    for (int c = 1; c <= 2 * FRAME; c++) begin
      @(negedge clk);
      if (sel !== 4'b0000) begin
        if (c <= FRAME) lit_cnt++;
        if (first_lit < 0) first_lit = c;
      end
      vectors++;
      if ({bus.upd_done, sel, seg} !== {exp_upd, exp_sel, exp_seg}) begin
        miscompares++;
        $display("FAIL pwm_model t=%0d: got %b/%b/%h, expected %b/%b/%h", m_t, bus.upd_done, sel, seg, exp_upd, exp_sel, exp_seg);
      end
    end
    // Slot positions 2,3 (pwm 2,3) and 16..19 (pwm 0..3) are lit: 6 per slot.
    vectors++;
    if (lit_cnt != 6 * ND) begin miscompares++; $display("FAIL pwm_duty: %0d lit cycles per frame, expected %0d", lit_cnt, 6 * ND); end
    // The sample after upd_done shows slot position 0; position BC shows up BC samples later.
    vectors++;
    if (first_lit != BC + 1) begin miscompares++; $display("FAIL pwm_latency: first lit sample %0d, expected %0d", first_lit, BC + 1); end
  endtask

  task automatic test_lz();
    bit seen;
    int n3, n2, n1, n0;
    bus.bright = 4'd15; bus.lz_en = 1'b1;
    send(16'h0070, 4'b0000, 4'hF);
    wait_upd(seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL lz_upd: upd_done=0, expected 1"); end
    n3 = 0; n2 = 0; n1 = 0; n0 = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (sel === 4'b1000 && seg === 8'hFF) n3++;
      if (sel === 4'b0100 && seg === 8'hFF) n2++;
      if (sel === 4'b0010 && seg === 8'hF8) n1++;
      if (sel === 4'b0001 && seg === 8'hC0) n0++;
      vectors++;
      if ({bus.upd_done, sel, seg} !== {exp_upd, exp_sel, exp_seg}) begin
        miscompares++;
        $display("FAIL lz_model t=%0d: got %b/%b/%h, expected %b/%b/%h", m_t, bus.upd_done, sel, seg, exp_upd, exp_sel, exp_seg);
      end
    end
    vectors++;
    if (n3 != 18 || n2 != 18 || n1 != 18 || n0 != 18) begin
      miscompares++;
      $display("FAIL lz_on_counts: d3=%0d d2=%0d d1=%0d d0=%0d, expected 18 each", n3, n2, n1, n0);
    end
    @(negedge clk);
    bus.lz_en = 1'b0;
    n3 = 0; n2 = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (sel === 4'b1000 && seg === 8'hC0) n3++;
      if (sel === 4'b0100 && seg === 8'hC0) n2++;
    end
    vectors++;
    if (n3 != 18 || n2 != 18) begin
      miscompares++;
      $display("FAIL lz_off_counts: d3=%0d d2=%0d showing c0, expected 18 each", n3, n2);
    end
  endtask

  task automatic test_back_to_back();
    int n2, n3, n1, nu;
    wait_phase(20);
    pulse_now(16'h1111, 4'b0000, 4'hF);
    wait_phase(50);
    pulse_now(16'h2222, 4'b0000, 4'hF);
    wait_phase(FRAME - 1);
    pulse_now(16'h3333, 4'b0000, 4'hF);
    vectors++;
    if (bus.upd_done !== 1'b1) begin miscompares++; $display("FAIL b2b_first_upd: upd_done=%b, expected 1", bus.upd_done); end
    n1 = 0; n2 = 0; nu = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (sel === 4'b0001 && seg === 8'hA4) n2++;
      if (sel === 4'b0001 && seg === 8'hF9) n1++;
      if (bus.upd_done === 1'b1) nu++;
      vectors++;
      if ({bus.upd_done, sel, seg} !== {exp_upd, exp_sel, exp_seg}) begin
        miscompares++;
        $display("FAIL b2b_model t=%0d: got %b/%b/%h, expected %b/%b/%h", m_t, bus.upd_done, sel, seg, exp_upd, exp_sel, exp_seg);
      end
    end
    vectors++;
    if (n2 != 18 || n1 != 0 || nu != 1) begin
      miscompares++;
      $display("FAIL b2b_frame1: 2222=%0d 1111=%0d upd=%0d, expected 18 0 1", n2, n1, nu);
    end
    n3 = 0; nu = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (sel === 4'b0001 && seg === 8'hB0) n3++;
      if (bus.upd_done === 1'b1) nu++;
    end
    vectors++;
    if (n3 != 18 || nu != 0) begin
      miscompares++;
      $display("FAIL b2b_frame2: 3333=%0d upd=%0d, expected 18 0", n3, nu);
    end
  endtask

  task automatic test_mask();
    bit seen;
    int n1, n3;
    send(16'($urandom), 4'($urandom), 4'b1010);
    wait_upd(seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL mask_upd: upd_done=0, expected 1"); end
    n1 = 0; n3 = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (sel === 4'b0010) n1++;
      if (sel === 4'b1000) n3++;
      vectors++;
      if (sel[0] !== 1'b0 || sel[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL mask_sel: sel=%b, expected bits 0 and 2 low", sel);
      end
      vectors++;
      if ({bus.upd_done, sel, seg} !== {exp_upd, exp_sel, exp_seg}) begin
        miscompares++;
        $display("FAIL mask_model t=%0d: got %b/%b/%h, expected %b/%b/%h", m_t, bus.upd_done, sel, seg, exp_upd, exp_sel, exp_seg);
      end
    end
    vectors++;
    if (n1 != 36 || n3 != 36) begin miscompares++; $display("FAIL mask_timing: d1=%0d d3=%0d, expected 36 each", n1, n3); end
  endtask

  task automatic test_random();
    bit seen;
    for (int it = 0; it < 5; it++) begin
      bus.bright = 4'($urandom_range(0, 15));
      bus.lz_en  = 1'($urandom);
      send(($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
           4'($urandom), 4'($urandom));
      wait_upd(seen);
      vectors++;
      if (!seen) begin miscompares++; $display("FAIL rand_upd it=%0d: upd_done=0, expected 1", it); end
      for (int c = 0; c < 2 * FRAME; c++) begin
        @(negedge clk);
        if (c == FRAME / 2) bus.bright = 4'($urandom_range(0, 15));
        vectors++;
        if ({bus.upd_done, sel, seg} !== {exp_upd, exp_sel, exp_seg}) begin
          miscompares++;
          $display("FAIL rand_model it=%0d t=%0d: got %b/%b/%h, expected %b/%b/%h", it, m_t, bus.upd_done, sel, seg, exp_upd, exp_sel, exp_seg);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.bright = 4'd15;
    bus.lz_en  = 1'b0;
    send(16'h8888, 4'hF, 4'hF);
    wait_phase(10);
    pulse_now(16'h5A5A, 4'hF, 4'hF);
    wait_phase(SD + 5);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (sel !== 4'b0000 || seg !== 8'hFF || bus.upd_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: sel=%b seg=%h upd=%b, expected 0000 ff 0", sel, seg, bus.upd_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      vectors++;
      if (sel !== 4'b0000 || seg !== 8'hFF || bus.upd_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_after c=%0d: sel=%b seg=%h upd=%b, expected 0000 ff 0", c, sel, seg, bus.upd_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pwm();
    test_lz();
    test_back_to_back();
    test_mask();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
